button_event_sampler: RTL and testbench
=======================================

Name: button_event_sampler

Overview:
- Input-side counterpart to the board LED output driver: samples front-panel pushbuttons instead of driving indicators.
- Each button is synchronised, debounced on a slow sample tick, and reported as a clean level plus one-cycle press/release event pulses.
- Output feeds the SoC GPIO/interrupt logic and the LED chaser control (start/stop/step).

Parameters:
- NUM_BTN, 4, number of independent button inputs (1..16).
- TICK_DIV, 50000, clk cycles per sample tick (>=2).
- STABLE_TICKS, 8, consecutive disagreeing sample ticks required to accept a level change (1..255).
- LONG_TICKS, 500, sample ticks of continuous press before long_pulse fires (>=1, only used with LONG_PRESS_EN).
- ACTIVE_LOW, 1, 1 = pressed pad reads 0; 0 = pressed pad reads 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- btn_in  in  NUM_BTN  raw asynchronous pad inputs.
- btn_level  out  NUM_BTN  debounced level, 1 = pressed (polarity normalised).
- press_pulse  out  NUM_BTN  one-clk pulse when btn_level goes 0->1.
- release_pulse  out  NUM_BTN  one-clk pulse when btn_level goes 1->0.
- long_pulse  out  NUM_BTN  one-clk pulse at long-press threshold.
- sample_tick  out  1  one-clk pulse per sample tick (debug/bench visibility).

Behaviour:
- Reset (async, rst=1):
  - All outputs 0; prescaler 0; all debounce and hold counters 0.
  - Synchroniser flops reset to the inactive pad level: all 1s if ACTIVE_LOW, else 0s.
  - So a button held through reset reports a press only after debounce once rst drops.
- Synchroniser: 2 flops per bit on btn_in; the second-stage value is XOR-ed with ACTIVE_LOW to give s[i] (1 = pressed).
- Prescaler:
  - Counts 0..TICK_DIV-1, wraps to 0.
  - sample_tick=1 in the cycle the count equals TICK_DIV-1; first tick occurs TICK_DIV cycles after reset release.
- Per-button debounce, evaluated only on sample_tick cycles; no state changes between ticks:
  - s[i]==btn_level[i]: cnt[i] <= 0.
  - s[i]!=btn_level[i] and cnt[i]+1 < STABLE_TICKS: cnt[i] <= cnt[i]+1.
  - s[i]!=btn_level[i] and cnt[i]+1 == STABLE_TICKS: btn_level[i] <= s[i], cnt[i] <= 0, and the matching press or release pulse is asserted for that same registered update.
  - Any agreeing tick mid-count restarts the count, so glitches shorter than STABLE_TICKS ticks are rejected.
- Pulse timing: press_pulse/release_pulse registered; high exactly in the cycle after the accepting tick, coincident with the new btn_level; width 1 clk.
- Latency: pad change to btn_level <= 2 sync cycles + STABLE_TICKS*TICK_DIV + 1 cycles.
- Buttons are fully independent; simultaneous events on several bits produce simultaneous pulses.
- Event exclusivity: press_pulse and release_pulse never both high on the same bit.
- Reset mid-count: all counters and levels are discarded; no pulse is emitted on reset entry or exit.

Optional Feature:
- Macro: BUTTON_LONG_PRESS_EN.
- Defined:
  - Per-button hold counter hcnt[i] cleared while btn_level[i]=0.
  - While btn_level[i]=1, hcnt[i] increments on each sample_tick, saturating at LONG_TICKS.
  - long_pulse[i]=1 for one clk, in the cycle after the tick where hcnt[i] reaches LONG_TICKS.
  - Fires at most once per press; re-arms only after release_pulse.
  - Release before threshold: no long_pulse.
- Not defined: long_pulse driven constant 0; no hold counters synthesised.

Test Plan (bench params TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=5, ACTIVE_LOW=1, NUM_BTN=4):
- Reset, btn_in=4'b1111 held 100 cycles -> all outputs 0; sample_tick period exactly 4 cycles.
- btn_in[0]=0 held -> btn_level[0]=1 with a single press_pulse[0] within 2+12+1 cycles; other bits stay 0.
- btn_in[1] low for 2 ticks, then high, then low again -> no event on the glitch; the later steady low is accepted 3 ticks after it starts.
- btn_in[0] and btn_in[3] released on the same cycle after both are pressed -> release_pulse=4'b1001 in a single cycle; btn_level=0.
- With BUTTON_LONG_PRESS_EN, btn_in[2] held low 10 ticks after acceptance -> exactly one long_pulse[2] at the 5th post-accept tick. Without the macro -> long_pulse stays 0.
- rst asserted while btn_in[0] is mid-debounce (cnt=2) -> outputs 0 immediately. After release, if pad is still low, a fresh 3-tick debounce completes before press_pulse.

Source files
------------

// File: rtl/button_event_sampler.sv
// button_event_sampler: synchronises, debounces and edge-detects pushbuttons on a slow sample tick.
// Define BUTTON_LONG_PRESS_EN to add per-button hold counters and long_pulse.
module button_event_sampler #(
  parameter int NUM_BTN      = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 8,
  parameter int LONG_TICKS   = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse,
  output logic               sample_tick
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [NUM_BTN-1:0] IDLE = (ACTIVE_LOW != 0) ? '1 : '0;
  logic [NUM_BTN-1:0] sync1, sync2, s;
  logic [PW-1:0] pcnt;
  // Sync flops idle at the released pad level so a held button still has to debounce after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end
  assign s = sync2 ^ IDLE;
  assign sample_tick = pcnt == PW'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt <= '0;
    else pcnt <= sample_tick ? '0 : pcnt + 1'b1;
  end
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    logic [7:0] cnt;
    logic lvl, pp, rp, acc;
    assign acc = (s[g] != lvl) && (cnt + 8'd1 == 8'(STABLE_TICKS));
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
        lvl <= 1'b0;
        pp  <= 1'b0;
        rp  <= 1'b0;
      end else begin
        pp <= sample_tick && acc && s[g];
        rp <= sample_tick && acc && !s[g];
        if (sample_tick) begin
          cnt <= (s[g] == lvl || acc) ? '0 : cnt + 8'd1;
          if (acc) lvl <= s[g];
        end
      end
    end
    assign btn_level[g]     = lvl;
    assign press_pulse[g]   = pp;
    assign release_pulse[g] = rp;
`ifdef BUTTON_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_TICKS + 1);
    logic [HW-1:0] hcnt;
    logic lp;
    // Saturating at LONG_TICKS makes the threshold fire once per press until release clears it
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hcnt <= '0;
        lp   <= 1'b0;
      end else begin
        lp <= sample_tick && lvl && hcnt == HW'(LONG_TICKS - 1);
        if (!lvl) hcnt <= '0;
        else if (sample_tick && hcnt != HW'(LONG_TICKS)) hcnt <= hcnt + 1'b1;
      end
    end
    assign long_pulse[g] = lp;
`else
    assign long_pulse[g] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_button_event_sampler.sv
// tb_button_event_sampler: scoreboard bench; expected events are queued with their exact cycle when stimulus is driven.
module tb_button_event_sampler;
  localparam int TD = 4;
  logic clk = 0, rst = 1;
  logic [3:0] btn_in = 4'hF;
  logic [3:0] btn_level, press_pulse, release_pulse, long_pulse;
  logic sample_tick;
  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic [3:0] p, r, l, lv;
    int c;
  } ev_t;
  ev_t obs[$];
  ev_t exp_q[$];

  button_event_sampler #(
    .NUM_BTN(4), .TICK_DIV(TD), .STABLE_TICKS(3), .LONG_TICKS(5), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (!rst && (press_pulse | release_pulse | long_pulse) != 4'b0)
      obs.push_back('{p: press_pulse, r: release_pulse, l: long_pulse, lv: btn_level, c: cyc});
  end

  // Returns at the negedge just after a tick edge; cycle counter then equals that edge number.
  task automatic align();
    int b = 0;
    @(negedge clk);
    while (!sample_tick && b < 4 * TD) begin
      @(negedge clk);
      b++;
    end
    n_tests++;
    if (!sample_tick) begin
      n_fail++;
      $display("FAIL align: sample_tick not seen within %0d cycles", 4 * TD);
    end
    @(negedge clk);
  endtask

  task automatic expect_ev(logic [3:0] p, logic [3:0] r, logic [3:0] l, logic [3:0] lv, int c);
    exp_q.push_back('{p: p, r: r, l: l, lv: lv, c: c});
  endtask

  task automatic settle_until(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset();
    int t1, t2, t3, b;
    rst = 1;
    btn_in = 4'hF;
    repeat (100) @(negedge clk);
    n_tests++;
    if ({btn_level, press_pulse, release_pulse, long_pulse, sample_tick} !== 17'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, want 0", {btn_level, press_pulse, release_pulse, long_pulse, sample_tick});
    end
    rst = 0;
    b = 0;
    t1 = -1; t2 = -1; t3 = -1;
    while (t3 < 0 && b < 10 * TD) begin
      @(negedge clk);
      b++;
      if (sample_tick) begin
        if (t1 < 0) t1 = cyc;
        else if (t2 < 0) t2 = cyc;
        else t3 = cyc;
      end
    end
    n_tests++;
    if (t3 < 0 || t2 - t1 != TD || t3 - t2 != TD) begin
      n_fail++;
      $display("FAIL tick_period: got %0d/%0d cycles, want %0d", t2 - t1, t3 - t2, TD);
    end
    repeat (100) @(negedge clk);
    n_tests++;
    if (obs.size() != 0 || btn_level !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_quiet: got %0d events level %b, want 0 events level 0000", obs.size(), btn_level);
    end
  endtask

  task automatic drain(string name);
    ev_t e, o;
    settle_until(exp_q[$].c + 2 * TD);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs.size() == 0) begin
        n_fail++;
        $display("FAIL %s: got no event, want p=%b r=%b l=%b lv=%b @%0d", name, e.p, e.r, e.l, e.lv, e.c);
      end else begin
        o = obs.pop_front();
        if ({o.p, o.r, o.l, o.lv, o.c} !== {e.p, e.r, e.l, e.lv, e.c}) begin
          n_fail++;
          $display("FAIL %s: got p=%b r=%b l=%b lv=%b @%0d, want p=%b r=%b l=%b lv=%b @%0d",
                   name, o.p, o.r, o.l, o.lv, o.c, e.p, e.r, e.l, e.lv, e.c);
        end
      end
    end
    n_tests++;
    if (obs.size() != 0) begin
      n_fail++;
      $display("FAIL %s_extra: got %0d unexpected events (first p=%b r=%b l=%b @%0d), want 0",
               name, obs.size(), obs[0].p, obs[0].r, obs[0].l, obs[0].c);
      obs.delete();
    end
  endtask

  task automatic test_press();
    align();
    btn_in[0] = 1'b0;
    expect_ev(4'b0001, 4'b0, 4'b0, 4'b0001, cyc + 3 * TD);
    drain("press0");
  endtask

  task automatic test_glitch();
    int c0;
    align();
    c0 = cyc;
    btn_in[1] = 1'b0;
    repeat (2 * TD) @(negedge clk);
    btn_in[1] = 1'b1;
    settle_until(c0 + 4 * TD);
    n_tests++;
    if (obs.size() != 0 || btn_level !== 4'b0001) begin
      n_fail++;
      $display("FAIL glitch_reject: got %0d events level %b, want 0 events level 0001", obs.size(), btn_level);
      obs.delete();
    end
    btn_in[1] = 1'b0;
    expect_ev(4'b0010, 4'b0, 4'b0, 4'b0011, cyc + 3 * TD);
    drain("glitch_then_press1");
  endtask

  task automatic test_back_to_back();
    align();
    btn_in[3] = 1'b0;
    expect_ev(4'b1000, 4'b0, 4'b0, 4'b1011, cyc + 3 * TD);
    drain("press3");
    align();
    btn_in[0] = 1'b1;
    btn_in[3] = 1'b1;
    expect_ev(4'b0, 4'b1001, 4'b0, 4'b0010, cyc + 3 * TD);
    drain("release_0_3");
  endtask

  task automatic test_long_press();
    int c0;
    align();
    c0 = cyc;
    btn_in[2] = 1'b0;
    expect_ev(4'b0100, 4'b0, 4'b0, 4'b0110, c0 + 3 * TD);
`ifdef BUTTON_LONG_PRESS_EN
    expect_ev(4'b0, 4'b0, 4'b0100, 4'b0110, c0 + 8 * TD);
`endif
    settle_until(c0 + 13 * TD);
    drain("long2_hold");
    align();
    btn_in[2] = 1'b1;
    expect_ev(4'b0, 4'b0100, 4'b0, 4'b0010, cyc + 3 * TD);
    drain("long2_release");
  endtask

  task automatic test_reset_mid();
    align();
    btn_in[0] = 1'b0;
    repeat (2 * TD + 1) @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({btn_level, press_pulse, release_pulse, long_pulse, sample_tick} !== 17'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h, want 0", {btn_level, press_pulse, release_pulse, long_pulse, sample_tick});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_ev(4'b0011, 4'b0, 4'b0, 4'b0011, cyc + 3 * TD);
    drain("reset_redebounce");
    align();
    btn_in[0] = 1'b1;
    btn_in[1] = 1'b1;
    expect_ev(4'b0, 4'b0011, 4'b0, 4'b0000, cyc + 3 * TD);
    drain("release_0_1");
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_back_to_back();
    test_long_press();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
